mem_access_stage: RTL and testbench

Memory-access (MEM) stage of the 5-stage RISC-V pipeline. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It performs loads and stores over a variable-latency data bus with a req/ack handshake, stalls the pipeline while an access is outstanding, and applies byte/half-word lane steering and sign extension. It produces the `rd_w` and `mux_mem_to_reg_w` values that the MEM/WB register captures.

---
 rtl/mem_access_stage.sv | 197 +++++++++++++++++++
 tb/tb_mem_access_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage RISC-V pipeline: load/store over a req/ack data bus
// with stall generation, byte-lane steering, load extension and bus timeout.
module mem_access_stage #(
    parameter int N       = 32,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_i,
    input  logic         mem_read_i,
    input  logic         mem_write_i,
    input  logic         mem_to_reg_i,
    input  logic [2:0]   funct3_i,
    input  logic [N-1:0] alu_result_i,
    input  logic [N-1:0] store_data_i,
    input  logic [4:0]   rd_i,
    output logic         bus_req_o,
    output logic         bus_we_o,
    output logic [N-1:0] bus_addr_o,
    output logic [N-1:0] bus_wdata_o,
    output logic [3:0]   bus_be_o,
    input  logic         bus_ack_i,
    input  logic [N-1:0] bus_rdata_i,
    output logic         stall_o,
    output logic         misalign_o,
    output logic         bus_err_o,
    output logic [N-1:0] rd_w,
    output logic [N-1:0] mux_mem_to_reg_w
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [CW-1:0]   cnt_r;
    logic [N-1:0]    result_r;
    logic            store_r;
    logic [2:0]      funct3_r;
    logic [1:0]      off_r;
    logic            mis_addr_s;
    logic            mem_op_s;
    logic            access_s;
    logic            timeout_s;

    // Byte enables for a given access size at a byte offset.
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   lane_be = 4'b0001 << off;
            2'b01:   lane_be = 4'b0011 << off;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    // Replicate store data across every lane the access could target.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] sd);
        case (size)
            2'b00:   lane_wdata = {4{sd[7:0]}};
            2'b01:   lane_wdata = {2{sd[15:0]}};
            default: lane_wdata = sd;
        endcase
    endfunction

    // Pick the addressed byte/half-word out of the read word and extend it.
    function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{off, 3'b000} +: 8];
        h = rdata[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  load_fmt = {{24{b[7]}}, b};
            3'b001:  load_fmt = {{16{h[15]}}, h};
            3'b100:  load_fmt = {24'h00_0000, b};
            3'b101:  load_fmt = {16'h0000, h};
            default: load_fmt = rdata;
        endcase
    endfunction

    // Alignment check; size code 11 is handled like a word.
    always_comb begin
        case (funct3_i[1:0])
            2'b00:   mis_addr_s = 1'b0;
            2'b01:   mis_addr_s = alu_result_i[0];
            default: mis_addr_s = |alu_result_i[1:0];
        endcase
    end

    assign mem_op_s   = valid_i & (mem_read_i | mem_write_i);
    assign access_s   = mem_op_s & ~mis_addr_s;
    assign misalign_o = mem_op_s & mis_addr_s;
    assign rd_w       = {{(N-5){1'b0}}, rd_i};

    // Next-state, stall and writeback mux.
    always_comb begin
        state_s          = state_r;
        stall_o          = 1'b0;
        timeout_s        = 1'b0;
        mux_mem_to_reg_w = {N{1'b0}};
        case (state_r)
            IDLE: begin
                if (misalign_o) begin
                    mux_mem_to_reg_w = {N{1'b0}};
                end else if (access_s) begin
                    stall_o = 1'b1;
                    state_s = BUSY;
                end else begin
                    mux_mem_to_reg_w = mem_to_reg_i ? {N{1'b0}} : alu_result_i;
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (bus_ack_i) begin
                    state_s = DONE;
                end else if (cnt_r == CNT_LAST) begin
                    state_s   = DONE;
                    timeout_s = 1'b1;
                end else begin
                    state_s = BUSY;
                end
            end
            DONE: begin
                state_s          = IDLE;
                mux_mem_to_reg_w = store_r ? alu_result_i : result_r;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Latched access, registered bus outputs, timeout counter and result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= {N{1'b0}};
            bus_wdata_o <= {N{1'b0}};
            bus_be_o    <= 4'b0000;
            bus_err_o   <= 1'b0;
            cnt_r       <= {CW{1'b0}};
            result_r    <= {N{1'b0}};
            store_r     <= 1'b0;
            funct3_r    <= 3'b000;
            off_r       <= 2'b00;
        end else begin
            bus_err_o <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (access_s) begin
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= mem_write_i;
                        bus_addr_o  <= {alu_result_i[N-1:2], 2'b00};
                        bus_be_o    <= lane_be(funct3_i[1:0], alu_result_i[1:0]);
                        bus_wdata_o <= lane_wdata(funct3_i[1:0], store_data_i);
                        store_r     <= mem_write_i;
                        funct3_r    <= funct3_i;
                        off_r       <= alu_result_i[1:0];
                        cnt_r       <= {CW{1'b0}};
                    end
                end
                BUSY: begin
                    cnt_r <= cnt_r + CW'(1);
                    if (bus_ack_i) begin
                        result_r  <= load_fmt(funct3_r, off_r, bus_rdata_i);
                        bus_req_o <= 1'b0;
                        bus_we_o  <= 1'b0;
                    end else if (timeout_s) begin
                        result_r  <= {N{1'b0}};
                        bus_err_o <= 1'b1;
                        bus_req_o <= 1'b0;
                        bus_we_o  <= 1'b0;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (TIMEOUT = 16).
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i, mem_read_i, mem_write_i, mem_to_reg_i;
    logic [2:0]  funct3_i;
    logic [31:0] alu_result_i, store_data_i;
    logic [4:0]  rd_i;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        stall_o, misalign_o, bus_err_o;
    logic [31:0] rd_w, mux_mem_to_reg_w;

    int n_checks = 0;
    int n_fail   = 0;

    int          stalls, reqs, errs;
    logic [31:0] res, be, wd, ad;
    logic        we;

    always #5 clk = ~clk;

    mem_access_stage #(.N(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .mem_read_i(mem_read_i),
        .mem_write_i(mem_write_i), .mem_to_reg_i(mem_to_reg_i), .funct3_i(funct3_i),
        .alu_result_i(alu_result_i), .store_data_i(store_data_i), .rd_i(rd_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o), .bus_ack_i(bus_ack_i),
        .bus_rdata_i(bus_rdata_i), .stall_o(stall_o), .misalign_o(misalign_o),
        .bus_err_o(bus_err_o), .rd_w(rd_w), .mux_mem_to_reg_w(mux_mem_to_reg_w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rdop, input logic wrop, input logic m2r,
                         input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [4:0] rd);
        @(posedge clk);
        #1;
        valid_i = v; mem_read_i = rdop; mem_write_i = wrop; mem_to_reg_i = m2r;
        funct3_i = f3; alu_result_i = addr; store_data_i = sd; rd_i = rd;
        #1;
    endtask

    // Starts in the accepting IDLE cycle; ends in the DONE cycle (stall dropped).
    task automatic do_access(input int ack_at, input logic [31:0] rdata,
                             output int st, output int rq, output int er,
                             output logic [31:0] r, output logic [31:0] b,
                             output logic [31:0] w, output logic [31:0] a, output logic e);
        bit done = 1'b0;
        st = 0; rq = 0; er = 0;
        r = 32'hxxxx_xxxx; b = 32'hxxxx_xxxx; w = 32'hxxxx_xxxx; a = 32'hxxxx_xxxx; e = 1'bx;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c > 0 && !stall_o) begin
                done = 1'b1;
                r = mux_mem_to_reg_w;
                if (bus_err_o) er++;
            end else begin
                if (stall_o) st++;
                if (bus_req_o) rq++;
                if (bus_err_o) er++;
                if (c == 1) begin
                    b = {28'h000_0000, bus_be_o}; w = bus_wdata_o; a = bus_addr_o; e = bus_we_o;
                end
                @(posedge clk);
                #1;
                bus_ack_i = (c + 1 == ack_at);
                bus_rdata_i = rdata;
                #1;
            end
        end
        bus_ack_i = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0; mem_to_reg_i = 1'b0;
        funct3_i = 3'b000; alu_result_i = 32'h0; store_data_i = 32'h0; rd_i = 5'd0;
        bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
        #12;
        check("rst_req", {31'h0, bus_req_o}, 32'h0);
        check("rst_we", {31'h0, bus_we_o}, 32'h0);
        check("rst_be", {28'h0, bus_be_o}, 32'h0);
        check("rst_addr", bus_addr_o, 32'h0);
        check("rst_wdata", bus_wdata_o, 32'h0);
        check("rst_err", {31'h0, bus_err_o}, 32'h0);
        check("rst_stall", {31'h0, stall_o}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Non-memory instruction passes the ALU result straight through.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 5'd7);
        check("alu_mux", mux_mem_to_reg_w, 32'h1234_5678);
        check("alu_stall", {31'h0, stall_o}, 32'h0);
        check("alu_rd_w", rd_w, 32'h0000_0007);

        // LW, ack in first BUSY cycle.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'h0, 5'd5);
        check("lw_idle_req", {31'h0, bus_req_o}, 32'h0);
        do_access(1, 32'hDEAD_BEEF, stalls, reqs, errs, res, be, wd, ad, we);
        check("lw_stalls", stalls, 2);
        check("lw_reqs", reqs, 1);
        check("lw_be", be, 32'h0000_000F);
        check("lw_addr", ad, 32'h0000_0100);
        check("lw_we", {31'h0, we}, 32'h0);
        check("lw_data", res, 32'hDEAD_BEEF);
        check("lw_err", errs, 0);
        check("lw_done_req", {31'h0, bus_req_o}, 32'h0);

        // LB at offset 3, ack after 2 cycles.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0, 5'd6);
        do_access(2, 32'h8011_2233, stalls, reqs, errs, res, be, wd, ad, we);
        check("lb_stalls", stalls, 3);
        check("lb_be", be, 32'h0000_0008);
        check("lb_addr", ad, 32'h0000_0100);
        check("lb_data", res, 32'hFFFF_FF80);

        // LBU at offset 3.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b100, 32'h0000_0103, 32'h0, 5'd6);
        do_access(1, 32'h8011_2233, stalls, reqs, errs, res, be, wd, ad, we);
        check("lbu_data", res, 32'h0000_0080);

        // LH at offset 2, ack after 3 cycles.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0, 5'd8);
        check("lh_misalign", {31'h0, misalign_o}, 32'h0);
        do_access(3, 32'h8011_2233, stalls, reqs, errs, res, be, wd, ad, we);
        check("lh_stalls", stalls, 4);
        check("lh_reqs", reqs, 3);
        check("lh_be", be, 32'h0000_000C);
        check("lh_data", res, 32'hFFFF_8011);

        // LHU at offset 0.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b101, 32'h0000_0100, 32'h0, 5'd8);
        do_access(1, 32'h1234_F00D, stalls, reqs, errs, res, be, wd, ad, we);
        check("lhu_data", res, 32'h0000_F00D);

        // SH at offset 2.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 5'd0);
        do_access(1, 32'h0, stalls, reqs, errs, res, be, wd, ad, we);
        check("sh_we", {31'h0, we}, 32'h1);
        check("sh_be", be, 32'h0000_000C);
        check("sh_wdata", wd, 32'hABCD_ABCD);
        check("sh_addr", ad, 32'h0000_0200);
        check("sh_done_mux", res, 32'h0000_0202);
        check("sh_stalls", stalls, 2);

        // SB at offset 1.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'h0000_0201, 32'h1234_5678, 5'd0);
        do_access(1, 32'h0, stalls, reqs, errs, res, be, wd, ad, we);
        check("sb_be", be, 32'h0000_0002);
        check("sb_wdata", wd, 32'h7878_7878);

        // Misaligned LW: flagged, no bus traffic, no stall.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0101, 32'h0, 5'd3);
        check("mis_flag", {31'h0, misalign_o}, 32'h1);
        check("mis_stall", {31'h0, stall_o}, 32'h0);
        check("mis_mux", mux_mem_to_reg_w, 32'h0);
        reqs = 0;
        stalls = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            if (bus_req_o) reqs++;
            if (stall_o) stalls++;
        end
        check("mis_reqs", reqs, 0);
        check("mis_stalls", stalls, 0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_0103, 32'h0, 5'd3);
        check("mis_lh_flag", {31'h0, misalign_o}, 32'h1);

        // Timeout: no ack.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'h0, 5'd9);
        do_access(0, 32'h5555_5555, stalls, reqs, errs, res, be, wd, ad, we);
        check("to_stalls", stalls, 17);
        check("to_reqs", reqs, 16);
        check("to_err", errs, 1);
        check("to_data", res, 32'h0);
        @(posedge clk);
        #2;
        check("to_err_pulse", {31'h0, bus_err_o}, 32'h0);

        // Next access proceeds normally.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'h0, 5'd9);
        do_access(1, 32'h0102_0304, stalls, reqs, errs, res, be, wd, ad, we);
        check("post_to_stalls", stalls, 2);
        check("post_to_data", res, 32'h0102_0304);
        check("post_to_err", errs, 0);

        // Ack on the very cycle the timeout expires: ack wins.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0108, 32'h0, 5'd10);
        do_access(16, 32'hCAFE_F00D, stalls, reqs, errs, res, be, wd, ad, we);
        check("race_stalls", stalls, 17);
        check("race_err", errs, 0);
        check("race_data", res, 32'hCAFE_F00D);

        // Reset while BUSY drops the request at once.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0400, 32'h0, 5'd11);
        @(posedge clk);
        #2;
        check("rb_busy_req", {31'h0, bus_req_o}, 32'h1);
        reset = 1'b0;
        #1;
        check("rb_req_drop", {31'h0, bus_req_o}, 32'h0);
        check("rb_be_clr", {28'h0, bus_be_o}, 32'h0);
        check("rb_addr_clr", bus_addr_o, 32'h0);
        valid_i = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        // After release the FSM behaves as IDLE and ignores a stray ack.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0000_0055, 32'h0, 5'd1);
        check("rb_idle_mux", mux_mem_to_reg_w, 32'h0000_0055);
        check("rb_idle_stall", {31'h0, stall_o}, 32'h0);
        bus_ack_i = 1'b1;
        @(posedge clk);
        #1;
        bus_ack_i = 1'b0;
        #1;
        check("rb_stray_req", {31'h0, bus_req_o}, 32'h0);
        check("rb_stray_mux", mux_mem_to_reg_w, 32'h0000_0055);
        check("rb_stray_stall", {31'h0, stall_o}, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0404, 32'h0, 5'd12);
        do_access(1, 32'h0BAD_F00D, stalls, reqs, errs, res, be, wd, ad, we);
        check("rb_after_stalls", stalls, 2);
        check("rb_after_data", res, 32'h0BAD_F00D);

        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
